// File: rtl/riscv_fetch.sv
// Instruction fetch stage: advances the register-file PC, keeps one instruction-memory
// read in flight and buffers fetched words for decode; execute redirects flush everything.
module riscv_fetch #(
  parameter int DEPTH = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] pc_val,
  output logic        enable_write_pc,
  output logic [31:0] pc_next,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  input  logic        imem_resp_error,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic        instr_fault
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW+1:0] DEPTH_W = (AW+2)'(DEPTH);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_REQ   = 3'd1,
    ST_WAIT  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_HALT  = 3'd4
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] req_pc_q, req_pc_d;

  logic [AW-1:0]    head_q, tail_q;
  logic [AW:0]      count_q;
  logic [31:0]      q_instr_q [DEPTH];
  logic [31:0]      q_pc_q    [DEPTH];
  logic [DEPTH-1:0] q_fault_q;

  logic        flush_s;
  logic        room_s;
  logic        aligned_s;
  logic [AW+1:0] occ_s;
  logic        push_s;
  logic        pop_s;
  logic [31:0] push_instr_s;
  logic [31:0] push_pc_s;
  logic        push_fault_s;

  // An in-flight read reserves a slot so its response can never overflow the queue.
  assign occ_s     = {1'b0, count_q} + {{(AW+1){1'b0}}, (state_q == ST_WAIT)};
  assign room_s    = (occ_s < DEPTH_W);
  assign aligned_s = (pc_val[1:0] == 2'b00);
  assign flush_s   = redirect_valid && (state_q != ST_IDLE);

  assign pc_next        = redirect_valid ? redirect_pc : (pc_val + 32'd4);
  assign imem_addr      = pc_val;
  assign imem_req_valid = (state_q == ST_REQ) && room_s && !redirect_valid && aligned_s;

  assign instr_valid = (count_q != {(AW+1){1'b0}});
  assign instr       = q_instr_q[head_q];
  assign instr_pc    = q_pc_q[head_q];
  assign instr_fault = q_fault_q[head_q];
  assign pop_s       = instr_valid && instr_ready && !flush_s;

  always_comb begin
    state_d         = state_q;
    req_pc_d        = req_pc_q;
    enable_write_pc = 1'b0;
    push_s          = 1'b0;
    push_instr_s    = 32'd0;
    push_pc_s       = 32'd0;
    push_fault_s    = 1'b0;
    if (flush_s) begin
      enable_write_pc = 1'b1;
      case (state_q)
        ST_WAIT:  state_d = imem_resp_valid ? ST_REQ : ST_DRAIN;
        ST_DRAIN: state_d = ST_DRAIN;
        default:  state_d = ST_REQ;
      endcase
    end else begin
      case (state_q)
        ST_IDLE: state_d = ST_REQ;
        ST_REQ: begin
          if (room_s && !aligned_s) begin
            push_s       = 1'b1;
            push_pc_s    = pc_val;
            push_fault_s = 1'b1;
            state_d      = ST_HALT;
          end else if (imem_req_valid && imem_req_ready) begin
            enable_write_pc = 1'b1;
            req_pc_d        = pc_val;
            state_d         = ST_WAIT;
          end else begin
            state_d = ST_REQ;
          end
        end
        ST_WAIT: begin
          if (imem_resp_valid) begin
            push_s       = 1'b1;
            push_instr_s = imem_resp_data;
            push_pc_s    = req_pc_q;
            push_fault_s = imem_resp_error;
            state_d      = imem_resp_error ? ST_HALT : ST_REQ;
          end else begin
            state_d = ST_WAIT;
          end
        end
        ST_DRAIN: state_d = imem_resp_valid ? ST_REQ : ST_DRAIN;
        ST_HALT:  state_d = ST_HALT;
        default:  state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      req_pc_q <= 32'd0;
    end else begin
      state_q  <= state_d;
      req_pc_q <= req_pc_d;
    end
  end

  // Circular instruction queue; a flush empties it and drops any same-cycle push/pop.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      head_q    <= {AW{1'b0}};
      tail_q    <= {AW{1'b0}};
      count_q   <= {(AW+1){1'b0}};
      q_fault_q <= {DEPTH{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        q_instr_q[i] <= 32'd0;
        q_pc_q[i]    <= 32'd0;
      end
    end else if (flush_s) begin
      head_q  <= {AW{1'b0}};
      tail_q  <= {AW{1'b0}};
      count_q <= {(AW+1){1'b0}};
    end else begin
      if (push_s) begin
        q_instr_q[tail_q] <= push_instr_s;
        q_pc_q[tail_q]    <= push_pc_s;
        q_fault_q[tail_q] <= push_fault_s;
        tail_q            <= tail_q + AW'(1);
      end
      if (pop_s) begin
        head_q <= head_q + AW'(1);
      end
      if (push_s && !pop_s) begin
        count_q <= count_q + (AW+1)'(1);
      end else if (!push_s && pop_s) begin
        count_q <= count_q - (AW+1)'(1);
      end
    end
  end

endmodule

// File: doc/riscv_fetch.md
# riscv_fetch

Instruction fetch stage of the RISC-V core. Sits directly upstream of the register file's PC and of decode. It reads the current PC, issues one instruction-memory read at a time and advances the PC through the register file's PC write port. Fetched words are buffered in a small queue for decode, and redirects from execute (branches, jumps) flush the queue and discard stale responses.

## Interface
Parameters:
- DEPTH, 2: instruction queue entries (power of two, ≥2).

Ports:
- clock  input  1  single clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low (0 = reset asserted).
- pc_val  input  32  current PC from the register file.
- enable_write_pc  output  1  PC write strobe to the register file.
- pc_next  output  32  PC write data to the register file.
- imem_req_valid  output  1  read request to instruction memory.
- imem_req_ready  input  1  memory accepts request this cycle.
- imem_addr  output  32  request address (= pc_val).
- imem_resp_valid  input  1  read data returned.
- imem_resp_data  input  32  instruction word.
- imem_resp_error  input  1  bus error for this response.
- redirect_valid  input  1  execute requests a PC change.
- redirect_pc  input  32  redirect target.
- instr_valid  output  1  queue head valid for decode.
- instr_ready  input  1  decode consumes head.
- instr  output  32  head instruction word.
- instr_pc  output  32  PC of head instruction.
- instr_fault  output  1  head is an access/alignment fault.

## Operation
- States: IDLE, REQ, WAIT, DRAIN, HALT. Reset → IDLE; IDLE → REQ unconditionally on the first clock after reset release.
- pc_next is combinational: redirect_valid ? redirect_pc : pc_val + 4 (mod 2^32, wraps 0xFFFFFFFC → 0).
- Free slots: room = count + (state==WAIT) < DEPTH.
- REQ:
  - imem_req_valid = room & !redirect_valid & pc_val[1:0]==0.
  - On valid&ready: latch req_pc = pc_val, enable_write_pc=1 (pc_next = pc_val+4), → WAIT.
  - If pc_val[1:0]!=0 and room and no redirect: push {instr=0, pc=pc_val, fault=1}, no request, → HALT.
- WAIT: on imem_resp_valid, push {imem_resp_data, req_pc, imem_resp_error}. → HALT if error, else → REQ.
- HALT: no requests until redirect.
- DRAIN: the next imem_resp_valid is discarded, then → REQ.
- Redirect (any state except IDLE) has top priority:
  - enable_write_pc=1, pc_next=redirect_pc.
  - Queue flushed (count=0, same-cycle pop and push suppressed).
  - From WAIT without a same-cycle response → DRAIN. From WAIT with a same-cycle response → drop it, → REQ. From DRAIN → stay DRAIN. Otherwise → REQ.
- enable_write_pc=0 in every other cycle.
- Queue: circular, head/tail pointers log2(DEPTH) bits plus count.
  - instr_valid = count!=0. instr/instr_pc/instr_fault come from the head entry (registered storage).
  - A pop on instr_valid&instr_ready coinciding with a push leaves count unchanged.
  - Overflow is impossible by the room rule.
- imem_req_valid is not sticky: it drops on a redirect even if the request was never accepted. The memory must tolerate this.
- Responses arriving in IDLE, REQ or HALT are ignored. This covers stale responses after a reset mid-transaction.

## Timing
- Reset values: state IDLE, count 0, instr_valid 0, imem_req_valid 0, enable_write_pc 0, instr/instr_pc/instr_fault 0.
- PC values on reset are owned by the register file.
- First request: earliest at cycle 1 after reset release (IDLE→REQ at cycle 0 edge).
- Request accepted at cycle T. With the response at T+k (k≥1), instr_valid rises at T+k+1.
- Throughput: at most one request per 2 cycles with zero-wait memory.
- Redirect at cycle T: PC written at edge T, and the new-target request is issued no earlier than T+1. In DRAIN, it is issued after the old response arrives.

## Test plan
- Zero-wait memory, pc_val=0, decode always ready → requests at 0x0, 0x4, 0x8. instr_pc sequence 0,4,8 with matching data. instr_valid 1 cycle after each response.
- instr_ready=0, DEPTH=2 → exactly 2 requests issued, then imem_req_valid=0. Popping one → a new request on the next REQ cycle.
- Redirect to 0x100 while in WAIT, old response 3 cycles later → old data never appears. The queue is empty after the redirect, and the next instr_pc is 0x100.
- Redirect in the same cycle as a response → response dropped, pc written to target, next instr_pc = target.
- imem_resp_error=1 on 0x20 → entry with instr_fault=1, instr_pc=0x20, then no requests. Redirect to 0x40 resumes fetch at 0x40.
- Redirect to 0x102 → fault entry with instr_pc=0x102 and no memory request. Asserting reset (0) mid-WAIT → all outputs return to reset values, and a late response is ignored.
